// File: rtl/osc_meter_pkg.sv
// Shared definitions for the oscillator period meter.
//   - state_e   : measurement FSM states
//   - W_DEF     : default counter/result width
//   - AVG_DEPTH : number of raw periods averaged when OSC_METER_AVG_EN is defined
//   - AVG_SHIFT : log2(AVG_DEPTH), used to divide the running sum
package osc_meter_pkg;
  localparam int W_DEF     = 24;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous input into the clk domain and produces edge events.
// Ports:
//   clk    : system clock
//   rst    : asynchronous reset, active low
//   sig_in : asynchronous input
//   rise   : one-cycle pulse, 3 cycles after sig_in rises
//   fall   : one-cycle pulse, 3 cycles after sig_in falls
//   level  : settled level of the input, aligned with rise/fall
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic level
);
  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sig_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      // Edge pulses are registered so they line up with s3_q.
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise  = rise_q;
  assign fall  = fall_q;
  assign level = s3_q;
endmodule

// File: rtl/osc_period_meter.sv
// Measures period and high time of an external square wave in clk cycles.
// Optional feature macro: OSC_METER_AVG_EN (period averaged over the last
// AVG_DEPTH raw periods, valid withheld until the history is full).
// Ports:
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   sig_in    : measured signal, asynchronous to clk
//   period    : cycles between the last two rising edges
//   high_time : cycles from rising to falling edge within that period
//   valid     : one-cycle strobe, period/high_time updated
//   locked    : a valid measurement exists since reset/timeout
//   timeout   : no rising edge for 2^W-1 cycles
module osc_period_meter
  import osc_meter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic rise, fall, level, rise_ev, fall_ev;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level)
  );

  // Pulses are only honoured when they agree with the settled level.
  assign rise_ev = rise & level;
  assign fall_ev = fall & ~level;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d, hi_lat_q, hi_lat_d;
  logic [W-1:0]   per_q, per_d, ht_q, ht_d;
  logic           vld_q, vld_d, lock_q, lock_d, to_q, to_d;
  logic           cap;  // a complete raw period is available this cycle

`ifdef OSC_METER_AVG_EN
  localparam logic [2:0] FILL_FULL = 3'(AVG_DEPTH);
  logic [AVG_DEPTH-1:0][W-1:0] hist_q, hist_d;
  logic [W+1:0]                sum_q, sum_d;
  logic [2:0]                  fill_q, fill_d;
  logic                        pend_q, pend_d;
  logic [W-1:0]                htp_q, htp_d;
  logic                        enter_to;

  assign enter_to = (state_q == MEASURE) && (state_d == TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    per_d    = per_q;
    ht_d     = ht_q;
    vld_d    = 1'b0;
    lock_d   = lock_q;
    to_d     = to_q;
    cap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_ev) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (fall_ev) hi_lat_d = cnt_q;
        if (rise_ev) begin
          cap   = 1'b1;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX - 1'b1) begin
          // cnt reaches its maximum on this edge: give up on the period.
          state_d = TIMEOUT;
          to_d    = 1'b1;
          lock_d  = 1'b0;
        end
      end
      TIMEOUT: begin
        if (rise_ev) begin
          to_d    = 1'b0;
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef OSC_METER_AVG_EN
    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    htp_d  = htp_q;
    pend_d = 1'b0;
    if (cap) begin
      // Running sum: drop the oldest entry, add the new one.
      hist_d = {hist_q[AVG_DEPTH-2:0], cnt_q};
      sum_d  = sum_q - {2'b00, hist_q[AVG_DEPTH-1]} + {2'b00, cnt_q};
      fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 3'd1;
      pend_d = (fill_q >= FILL_FULL - 3'd1);
      htp_d  = hi_lat_q;
    end
    if (pend_q) begin
      per_d  = W'(sum_q >> AVG_SHIFT);
      ht_d   = htp_q;
      vld_d  = 1'b1;
      lock_d = 1'b1;
    end
    if (enter_to) begin
      hist_d = '0;
      sum_d  = '0;
      fill_d = '0;
    end
`else
    if (cap) begin
      per_d  = cnt_q;
      ht_d   = hi_lat_q;
      vld_d  = 1'b1;
      lock_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      per_q    <= '0;
      ht_q     <= '0;
      vld_q    <= 1'b0;
      lock_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      per_q    <= per_d;
      ht_q     <= ht_d;
      vld_q    <= vld_d;
      lock_q   <= lock_d;
      to_q     <= to_d;
    end
  end

`ifdef OSC_METER_AVG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      htp_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
      pend_q <= pend_d;
      htp_q  <= htp_d;
    end
  end
`endif

  assign period    = per_q;
  assign high_time = ht_q;
  assign valid     = vld_q;
  assign locked    = lock_q;
  assign timeout   = to_q;
endmodule

// File: tb/tb_osc_period_meter.sv
// Self-checking bench for osc_period_meter: one W=24 and one W=8 instance
// driven by the same wave. Honours OSC_METER_AVG_EN if defined.
module tb_osc_period_meter;
  localparam int MAXA = (1 << 24) - 1;
  localparam int MAXB = (1 << 8) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [23:0] a_period, a_high;
  logic [7:0]  b_period, b_high;
  logic        a_valid, a_locked, a_timeout;
  logic        b_valid, b_locked, b_timeout;

  osc_period_meter #(.W(24)) u_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(a_period), .high_time(a_high),
    .valid(a_valid), .locked(a_locked), .timeout(a_timeout));
  osc_period_meter #(.W(8)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(b_period), .high_time(b_high),
    .valid(b_valid), .locked(b_locked), .timeout(b_timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed valid results
  int obs_pa[$], obs_ha[$], obs_pb[$], obs_hb[$];
  always @(negedge clk) begin
    if (a_valid) begin obs_pa.push_back(int'(a_period)); obs_ha.push_back(int'(a_high)); end
    if (b_valid) begin obs_pb.push_back(int'(b_period)); obs_hb.push_back(int'(b_high)); end
  end

  // Reference model: wave described as (high, gap) per period
  int exp_pa[$], exp_ha[$], exp_pb[$], exp_hb[$];
  int hist0[$], hist1[$];
  bit have_prev0, have_prev1;
  bit use_model;
  int pend_h, pend_gap;
  int last_p1, last_h1;

  typedef struct { int hi; int lo; int per; int ht; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int p, input int h);
    if (i == 0) begin exp_pa.push_back(p); exp_ha.push_back(h); end
    else begin exp_pb.push_back(p); exp_hb.push_back(h); last_p1 = p; last_h1 = h; end
  endtask

  task automatic emit(input int i, input int gap, input int h);
`ifdef OSC_METER_AVG_EN
    int tmp;
    if (i == 0) begin
      hist0.push_back(gap);
      if (hist0.size() > 4) tmp = hist0.pop_front();
      if (hist0.size() == 4) push_exp(0, (hist0[0] + hist0[1] + hist0[2] + hist0[3]) / 4, h);
    end else begin
      hist1.push_back(gap);
      if (hist1.size() > 4) tmp = hist1.pop_front();
      if (hist1.size() == 4) push_exp(1, (hist1[0] + hist1[1] + hist1[2] + hist1[3]) / 4, h);
    end
`else
    push_exp(i, gap, h);
`endif
  endtask

  // Called at every rising edge of sig_in; the previous edge closes a period.
  task automatic model_edge();
    if (use_model) begin
      if (have_prev0) begin
        if (pend_gap >= MAXA) hist0.delete(); else emit(0, pend_gap, pend_h);
      end
      if (have_prev1) begin
        if (pend_gap >= MAXB) hist1.delete(); else emit(1, pend_gap, pend_h);
      end
    end
    have_prev0 = 1'b1;
    have_prev1 = 1'b1;
  endtask

  task automatic model_reset();
    have_prev0 = 1'b0; have_prev1 = 1'b0;
    hist0.delete(); hist1.delete();
    exp_pa.delete(); exp_ha.delete(); exp_pb.delete(); exp_hb.delete();
    obs_pa.delete(); obs_ha.delete(); obs_pb.delete(); obs_hb.delete();
  endtask

  task automatic drive(input int h, input int l);
    model_edge();
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
    pend_h = h;
    pend_gap = h + l;
  endtask

  task automatic check_q(input string nm);
    int n;
    chk({nm, " a count"}, obs_pa.size(), exp_pa.size());
    chk({nm, " b count"}, obs_pb.size(), exp_pb.size());
    n = (obs_pa.size() < exp_pa.size()) ? obs_pa.size() : exp_pa.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s a period[%0d]", nm, i), obs_pa[i], exp_pa[i]);
      chk($sformatf("%s a high[%0d]", nm, i), obs_ha[i], exp_ha[i]);
    end
    n = (obs_pb.size() < exp_pb.size()) ? obs_pb.size() : exp_pb.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s b period[%0d]", nm, i), obs_pb[i], exp_pb[i]);
      chk($sformatf("%s b high[%0d]", nm, i), obs_hb[i], exp_hb[i]);
    end
    exp_pa.delete(); exp_ha.delete(); exp_pb.delete(); exp_hb.delete();
    obs_pa.delete(); obs_ha.delete(); obs_pb.delete(); obs_hb.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " a period"}, int'(a_period), 0);
    chk({nm, " a high"}, int'(a_high), 0);
    chk({nm, " a flags"}, int'({a_valid, a_locked, a_timeout}), 0);
    chk({nm, " b period"}, int'(b_period), 0);
    chk({nm, " b high"}, int'(b_high), 0);
    chk({nm, " b flags"}, int'({b_valid, b_locked, b_timeout}), 0);
  endtask

  // Asynchronous reset between clock edges, then release with sig_in low.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 chk_zero(nm);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int c0, spent, ehi;
    rst = 1'b0;
    sig_in = 1'b0;
    use_model = 1'b1;
    pend_h = 0; pend_gap = 0; last_p1 = 0; last_h1 = 0;
    tbl[0] = '{30, 70, 100, 30};
    tbl[1] = '{30, 70, 100, 30};
    tbl[2] = '{20, 40, 60, 20};
    tbl[3] = '{20, 40, 60, 20};
    tbl[4] = '{1, 1, 2, 1};
    tbl[5] = '{1, 3, 4, 1};
    tbl[6] = '{200, 54, 254, 200};
    tbl[7] = '{3, 2, 5, 3};
    model_reset();

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table: first edge gives nothing, each later edge closes the previous entry.
`ifdef OSC_METER_AVG_EN
    use_model = 1'b1;
`else
    use_model = 1'b0;
`endif
    foreach (tbl[i]) drive(tbl[i].hi, tbl[i].lo);
    drive(8, 8);
`ifndef OSC_METER_AVG_EN
    foreach (tbl[i]) begin push_exp(0, tbl[i].per, tbl[i].ht); push_exp(1, tbl[i].per, tbl[i].ht); end
    chk("table a locked", int'(a_locked), 1);
    chk("table b locked", int'(b_locked), 1);
`endif
    use_model = 1'b1;
    check_q("table");

    // Randomized periods, all below the W=8 limit
    repeat (20) drive(int'($urandom_range(1, 120)), int'($urandom_range(1, 120)));
    drive(8, 8);
    check_q("random");

    // Input stuck high: W=8 instance times out, W=24 keeps measuring
    drive(30, 70);
    model_edge();
    sig_in = 1'b1;
    c0 = cyc;
    spent = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      spent++;
      if (b_timeout) break;
    end
    chk("b timeout delay", cyc - c0, 258);
    chk("b timeout flag", int'(b_timeout), 1);
    chk("b locked in timeout", int'(b_locked), 0);
    chk("b period held", int'(b_period), last_p1);
    chk("b high held", int'(b_high), last_h1);
    chk("a no timeout", int'(a_timeout), 0);
    chk("a still locked", int'(a_locked), 1);
    repeat (300 - spent) @(negedge clk);
    sig_in = 1'b0;
    repeat (100) @(negedge clk);
    pend_h = 300; pend_gap = 400;
    model_edge();
    sig_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("b timeout cleared", int'(b_timeout), 0);
    chk("b locked after restart", int'(b_locked), 0);
    repeat (20) @(negedge clk);
    sig_in = 1'b0;
    repeat (70) @(negedge clk);
    pend_h = 30; pend_gap = 100;
    drive(8, 8);
    check_q("timeout");
    chk("b relocked", int'(b_locked), 1);

    // Reset in the middle of a period
    drive(30, 70);
    model_edge();
    sig_in = 1'b1;
    repeat (30) @(negedge clk);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    check_q("pre-reset");
    do_reset("mid reset");
    repeat (3) @(negedge clk);
    drive(25, 50);
    chk("no valid after first edge", obs_pa.size(), 0);
    drive(25, 50);
    drive(8, 8);
    check_q("post-reset");

`ifdef OSC_METER_AVG_EN
    do_reset("avg reset");
    repeat (3) @(negedge clk);
    use_model = 1'b0;
    for (int i = 0; i < 3; i++) drive(30, 70);
    for (int i = 0; i < 5; i++) drive(30, 74);
    drive(8, 8);
    ehi = 30;
    push_exp(0, 101, ehi); push_exp(0, 102, ehi); push_exp(0, 103, ehi);
    push_exp(0, 104, ehi); push_exp(0, 104, ehi);
    push_exp(1, 101, ehi); push_exp(1, 102, ehi); push_exp(1, 103, ehi);
    push_exp(1, 104, ehi); push_exp(1, 104, ehi);
    check_q("average");
`else
    ehi = 0;
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
